// File: rtl/motor_drive_sequencer.sv
// Two-channel H-bridge sequencer for the rover drive. It enforces coast dead-time on reversal,
// trips on filtered overcurrent with timed cool-down and retry, and latches a lockout after repeated faults.
//
// state     | meaning
// IDLE  (0) | coast, waiting for a drive or brake request
// RUN   (1) | drive latched direction, PWM enabled
// DEAD  (2) | coast for DEAD_CYCLES before a new drive direction
// BRAKE (3) | both low-side paths on (11)
// FAULT (4) | coast for COOL_CYCLES after an overcurrent trip
// LOCK  (5) | coast, fault flagged until cleared with stop request

module motor_channel #(
   parameter int DEAD_CYCLES = 100000,
   parameter int COOL_CYCLES = 50000000,
   parameter int CMP_FILTER  = 4,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       comp,
   input  logic       clear_s,
   output logic       in1,
   output logic       in2,
   output logic       run,
   output logic       fault,
   output logic [2:0] state_code
);

   localparam int TMAX = (DEAD_CYCLES > COOL_CYCLES) ? DEAD_CYCLES : COOL_CYCLES;
   localparam int TW   = $clog2(TMAX);
   localparam int FW   = (CMP_FILTER > 1) ? $clog2(CMP_FILTER) : 1;

   localparam logic [TW-1:0] DEAD_LOAD = TW'(DEAD_CYCLES - 1);
   localparam logic [TW-1:0] COOL_LOAD = TW'(COOL_CYCLES - 1);
   localparam logic [FW-1:0] FLT_LAST  = FW'(CMP_FILTER - 1);
   localparam logic [2:0]    RETRY_LIM = 3'(MAX_RETRY);

   localparam logic [1:0] REQ_STOP  = 2'b00;
   localparam logic [1:0] REQ_FWD   = 2'b01;
   localparam logic [1:0] REQ_REV   = 2'b10;
   localparam logic [1:0] REQ_BRAKE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RUN   = 3'd1,
      ST_DEAD  = 3'd2,
      ST_BRAKE = 3'd3,
      ST_FAULT = 3'd4,
      ST_LOCK  = 3'd5
   } state_t;

   state_t        state, nxt_state;
   logic          dir_rev, nxt_dir_rev;
   logic [TW-1:0] timer, nxt_timer;
   logic [2:0]    retry_cnt, nxt_retry;
   logic [FW-1:0] flt_cnt, nxt_flt;
   logic [1:0]    req_s1, req_s2;
   logic          comp_s1, comp_s2;
   logic          trip;

   always_comb begin
      nxt_state   = state;
      nxt_dir_rev = dir_rev;
      nxt_timer   = timer;
      nxt_retry   = retry_cnt;
      nxt_flt     = '0;
      trip        = (state == ST_RUN) && comp_s2 && (flt_cnt == FLT_LAST);
      case (state)
         ST_IDLE: begin
            case (req_s2)
               REQ_FWD:   begin nxt_state = ST_RUN; nxt_dir_rev = 1'b0; end
               REQ_REV:   begin nxt_state = ST_RUN; nxt_dir_rev = 1'b1; end
               REQ_BRAKE: nxt_state = ST_BRAKE;
               default:   nxt_retry = '0;
            endcase
         end
         ST_RUN: begin
            // Overcurrent outranks any simultaneous request change.
            if (trip) begin
               nxt_state = ST_FAULT;
               nxt_timer = COOL_LOAD;
               if (retry_cnt != 3'd7) nxt_retry = retry_cnt + 3'd1;
            end else begin
               case (req_s2)
                  REQ_STOP:  nxt_state = ST_IDLE;
                  REQ_BRAKE: nxt_state = ST_BRAKE;
                  REQ_FWD: begin
                     if (dir_rev) begin nxt_state = ST_DEAD; nxt_timer = DEAD_LOAD; end
                  end
                  default: begin
                     if (!dir_rev) begin nxt_state = ST_DEAD; nxt_timer = DEAD_LOAD; end
                  end
               endcase
            end
         end
         ST_DEAD: begin
            if (timer == '0) begin
               case (req_s2)
                  REQ_FWD:   begin nxt_state = ST_RUN; nxt_dir_rev = 1'b0; end
                  REQ_REV:   begin nxt_state = ST_RUN; nxt_dir_rev = 1'b1; end
                  REQ_BRAKE: nxt_state = ST_BRAKE;
                  default:   nxt_state = ST_IDLE;
               endcase
            end else begin
               nxt_timer = timer - TW'(1);
            end
         end
         ST_BRAKE: begin
            case (req_s2)
               REQ_STOP:  nxt_state = ST_IDLE;
               REQ_BRAKE: nxt_state = ST_BRAKE;
               default: begin nxt_state = ST_DEAD; nxt_timer = DEAD_LOAD; end
            endcase
         end
         ST_FAULT: begin
            if (timer == '0) nxt_state = (retry_cnt >= RETRY_LIM) ? ST_LOCK : ST_IDLE;
            else             nxt_timer = timer - TW'(1);
         end
         ST_LOCK: begin
            if (clear_s && (req_s2 == REQ_STOP)) begin
               nxt_state = ST_IDLE;
               nxt_retry = '0;
            end
         end
         default: nxt_state = ST_IDLE;
      endcase
      if ((state == ST_RUN) && (nxt_state == ST_RUN) && comp_s2) nxt_flt = flt_cnt + FW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_s1     <= '0;
         req_s2     <= '0;
         comp_s1    <= 1'b0;
         comp_s2    <= 1'b0;
         state      <= ST_IDLE;
         dir_rev    <= 1'b0;
         timer      <= '0;
         retry_cnt  <= '0;
         flt_cnt    <= '0;
         in1        <= 1'b0;
         in2        <= 1'b0;
         run        <= 1'b0;
         fault      <= 1'b0;
         state_code <= 3'd0;
      end else begin
         req_s1     <= req;
         req_s2     <= req_s1;
         comp_s1    <= comp;
         comp_s2    <= comp_s1;
         state      <= nxt_state;
         dir_rev    <= nxt_dir_rev;
         timer      <= nxt_timer;
         retry_cnt  <= nxt_retry;
         flt_cnt    <= nxt_flt;
         // Outputs decoded from next state so they register alongside it.
         in1        <= ((nxt_state == ST_RUN) && !nxt_dir_rev) || (nxt_state == ST_BRAKE);
         in2        <= ((nxt_state == ST_RUN) && nxt_dir_rev) || (nxt_state == ST_BRAKE);
         run        <= (nxt_state == ST_RUN);
         fault      <= (nxt_state == ST_LOCK);
         state_code <= nxt_state;
      end
   end

endmodule

module motor_drive_sequencer #(
   parameter int DEAD_CYCLES = 100000,
   parameter int COOL_CYCLES = 50000000,
   parameter int CMP_FILTER  = 4,
   parameter int MAX_RETRY   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_a,
   input  logic [1:0] req_b,
   input  logic       compA,
   input  logic       compB,
   input  logic       clear_fault,
   output logic       JA1,
   output logic       JA2,
   output logic       JA3,
   output logic       JA4,
   output logic       run_a,
   output logic       run_b,
   output logic [2:0] state_a,
   output logic [2:0] state_b,
   output logic       fault_a,
   output logic       fault_b
);

   logic clr_s1, clr_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_s1 <= 1'b0;
         clr_s2 <= 1'b0;
      end else begin
         clr_s1 <= clear_fault;
         clr_s2 <= clr_s1;
      end
   end

   motor_channel #(
      .DEAD_CYCLES(DEAD_CYCLES), .COOL_CYCLES(COOL_CYCLES),
      .CMP_FILTER(CMP_FILTER), .MAX_RETRY(MAX_RETRY)
   ) u_chan_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .comp(compA), .clear_s(clr_s2),
      .in1(JA1), .in2(JA2), .run(run_a), .fault(fault_a), .state_code(state_a)
   );

   motor_channel #(
      .DEAD_CYCLES(DEAD_CYCLES), .COOL_CYCLES(COOL_CYCLES),
      .CMP_FILTER(CMP_FILTER), .MAX_RETRY(MAX_RETRY)
   ) u_chan_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .comp(compB), .clear_s(clr_s2),
      .in1(JA3), .in2(JA4), .run(run_b), .fault(fault_b), .state_code(state_b)
   );

endmodule

// File: doc/motor_drive_sequencer.md
# motor_drive_sequencer

Per-motor H-bridge sequencer for the two-motor rover drive. It takes the operator's per-motor direction requests (switch-derived) and the overcurrent comparators compA/compB, and drives the bridge inputs JA1–JA4 with enforced dead-time on reversal. It also handles overcurrent shutdown with timed cool-down and retry, and a latched lockout after repeated faults. It sits between the switch/input logic and the PWM and motor-driver stage; run_a/run_b gate the PWM enables downstream.

## Interface
- DEAD_CYCLES, 100000, coast time before any direction change or brake-to-drive (1 ms at 100 MHz), ≥2
- COOL_CYCLES, 50000000, coast time after an overcurrent trip (0.5 s), ≥2
- CMP_FILTER, 4, consecutive synchronized high samples of compX that constitute a fault, ≥1
- MAX_RETRY, 3, trips allowed before lockout, 1–7
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- req_a, req_b  in  2  motor request: 00 stop, 01 forward, 10 reverse, 11 brake; asynchronous, 2-flop synchronized
- compA, compB  in  1  overcurrent comparator, high = overcurrent; asynchronous, 2-flop synchronized
- clear_fault  in  1  level; releases lockout (synchronized)
- JA1, JA2  out  1  motor A IN1/IN2; JA3, JA4  out  1  motor B IN1/IN2
- run_a, run_b  out  1  PWM gate: high only in RUN
- state_a, state_b  out  3  FSM state code, for LED/7-seg
- fault_a, fault_b  out  1  high in LOCK

## Operation
- Two identical, independent channels. Bridge encoding: forward 10, reverse 01, coast 00, brake 11. Outputs are Moore-decoded from registered state and latched direction.
- States (code): IDLE(0) coast; RUN(1) drive latched dir, run=1; DEAD(2) coast; BRAKE(3) 11; FAULT(4) coast; LOCK(5) coast, fault=1.
- IDLE: fwd/rev → RUN, latch dir; brake → BRAKE; stop → stay, retry_cnt cleared.
- RUN: filtered overcurrent → FAULT (highest priority); stop → IDLE; brake → BRAKE; opposite dir → DEAD; same dir → stay.
- DEAD: timer runs DEAD_CYCLES. At expiry the synchronized request is evaluated: fwd/rev → RUN with that dir latched; stop → IDLE; brake → BRAKE. Request changes during DEAD do not restart the timer.
- BRAKE: stop → IDLE; fwd/rev → DEAD; brake → stay.
- FAULT: retry_cnt increments on entry (saturating at 7); timer runs COOL_CYCLES. At expiry: retry_cnt ≥ MAX_RETRY → LOCK, else → IDLE.
- LOCK: exits to IDLE only when clear_fault=1 and req=00 on the same cycle; retry_cnt cleared on exit. clear_fault with req≠00 has no effect.
- Overcurrent filter counter increments while in RUN with synced comp=1. It clears on any synced comp=0 or outside RUN. comp is ignored outside RUN.
- Reset values: state IDLE, JA1–JA4 = 0, run=0, fault=0, state_x=0, retry_cnt=0, timers and sync flops 0.

## Timing
- Request latency: a req change settled before edge 1 is synced at edge 2, the state changes at edge 3, and outputs follow after edge 3.
- Fault latency: compX held high from before edge 1 (in RUN) → FAULT registered at edge 2+CMP_FILTER; coast after edge 6 with the default. A high pulse shorter than CMP_FILTER synced samples causes no trip.
- DEAD entered at edge E → exit at edge E+DEAD_CYCLES, giving exactly DEAD_CYCLES cycles of coast. FAULT is identical with COOL_CYCLES.
- A direct fwd↔rev or brake→drive bridge transition without an intervening DEAD is forbidden on every cycle.
- Simultaneous overcurrent trip and request change in RUN: FAULT wins.
- Reset asserted mid-operation: outputs go to coast immediately (asynchronously). Operation resumes from IDLE at the first edge after release.

## Test plan
Parameters for all scenarios: DEAD_CYCLES=8, COOL_CYCLES=20, CMP_FILTER=4, MAX_RETRY=3.
- Reset, then req_a=01 → JA1/JA2=10 and run_a=1 three edges after the change; state_a=1; motor B stays 00.
- RUN forward, req_a=10 → coast for exactly 8 cycles, then JA1/JA2=01. Verify 11 and 01 are never seen adjacent to 10.
- compA high for 3 cycles in RUN → no trip. compA held high → coast 6 edges after assertion, state_a=4, coast for 20 cycles, then back to RUN because the request is still 01.
- Three sustained trips with req_a=01 → after the third cool-down, state_a=5 and fault_a=1. clear_fault=1 with req_a=01 → stays LOCK. req_a=00 with clear_fault=1 → IDLE, fault_a=0.
- RUN on both motors, compB trips on the same edge that req_a changes to 10 → motor B enters FAULT and motor A enters DEAD, independently.
- reset low mid-DEAD and mid-FAULT → JA1–JA4=0000, run=0, state=0 immediately. After release, req=01 reaches RUN with a full 3-edge latency.
